inst_rom_arbiter: RTL and testbench

- Shares the single combinational instruction ROM read port between two requesters: instruction fetch (IF) and a data-side read port (DP) used for constant loads and debug reads of code space.
- Drives the ROM chip-enable and address, registers the returned word, and routes it back to the winning requester one cycle later.
- IF has fixed priority. A starvation counter guarantees DP progress. An IF flush discards an in-flight fetch response.
- Sits between the IF stage / MEM-stage read mux and the instruction ROM.

---
 rtl/inst_rom_arbiter_pkg.sv | 18 +
 rtl/inst_rom_prio_sel.sv | 44 ++++
 rtl/inst_rom_arbiter.sv | 81 ++++++++
 tb/tb_inst_rom_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/inst_rom_arbiter_pkg.sv
// Shared widths and response-owner encoding for the instruction ROM arbiter.
// Owner encoding follows the codebase defines: NONE=0, IF=1, DP=2.
package inst_rom_arbiter_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DP   = 2'd2
    } owner_e;

    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return |i_lsb;
    endfunction

endpackage

// File: rtl/inst_rom_prio_sel.sv
// Grant selector for the shared ROM port: IF has fixed priority, and a
// saturating starvation counter forces a DP grant after STARVE_LIMIT denials.
module inst_rom_prio_sel #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_if_req,
    input  logic i_dp_req,
    output logic o_if_gnt,
    output logic o_dp_gnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_dp_force;

    assign w_dp_force = i_dp_req && (r_starve_cnt >= LIMIT);

    always_comb begin
        o_if_gnt = 1'b0;
        o_dp_gnt = 1'b0;
        if (w_dp_force) begin
            o_dp_gnt = 1'b1;
        end else if (i_if_req) begin
            o_if_gnt = 1'b1;
        end else if (i_dp_req) begin
            o_dp_gnt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (i_dp_req && !o_dp_gnt) begin
            r_starve_cnt <= (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the combinational instruction ROM between fetch (IF) and a data-side
// read port (DP); the returned word is registered and routed to the winner.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W       = INST_ADDR_W,
    parameter int DATA_W       = INST_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dp_req,
    input  logic [ADDR_W-1:0] i_dp_addr,
    output logic              o_dp_gnt,
    output logic              o_dp_rvalid,
    output logic [DATA_W-1:0] o_dp_rdata,
    output logic              o_dp_err,
    output logic              o_rom_ce,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_inst
);

    owner_e            r_owner;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dp_rdata;
    logic              r_dp_err;
    logic              w_if_gnt;
    logic              w_dp_gnt;

    inst_rom_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio_sel (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_if_req (i_if_req),
        .i_dp_req (i_dp_req),
        .o_if_gnt (w_if_gnt),
        .o_dp_gnt (w_dp_gnt)
    );

    assign o_if_gnt   = w_if_gnt;
    assign o_dp_gnt   = w_dp_gnt;
    assign o_rom_ce   = w_if_gnt | w_dp_gnt;
    assign o_rom_addr = w_dp_gnt ? i_dp_addr : (w_if_gnt ? i_if_addr : '0);

    // The owner register doubles as the valid flag: a flushed fetch leaves it NONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner    <= OWN_NONE;
            r_if_rdata <= '0;
            r_dp_rdata <= '0;
            r_dp_err   <= 1'b0;
        end else if (w_dp_gnt) begin
            r_owner    <= OWN_DP;
            r_dp_rdata <= i_rom_inst;
            r_dp_err   <= is_misaligned(i_dp_addr[1:0]);
        end else if (w_if_gnt) begin
            r_owner    <= i_if_flush ? OWN_NONE : OWN_IF;
            r_if_rdata <= i_rom_inst;
            r_dp_err   <= 1'b0;
        end else begin
            r_owner    <= OWN_NONE;
            r_dp_err   <= 1'b0;
        end
    end

    assign o_if_rvalid = (r_owner == OWN_IF);
    assign o_dp_rvalid = (r_owner == OWN_DP);
    assign o_if_rdata  = r_if_rdata;
    assign o_dp_rdata  = r_dp_rdata;
    assign o_dp_err    = r_dp_err;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter with a behavioural combinational ROM.
module tb_inst_rom_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req, if_flush, dp_req;
    logic [31:0] if_addr, dp_addr;
    logic        if_gnt, if_rvalid, dp_gnt, dp_rvalid, dp_err, rom_ce;
    logic [31:0] if_rdata, dp_rdata, rom_addr, rom_inst;
    logic [31:0] mem [64];
    int          n_checks;
    int          n_fail;

    inst_rom_arbiter u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .i_if_flush  (if_flush),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_dp_req    (dp_req),
        .i_dp_addr   (dp_addr),
        .o_dp_gnt    (dp_gnt),
        .o_dp_rvalid (dp_rvalid),
        .o_dp_rdata  (dp_rdata),
        .o_dp_err    (dp_err),
        .o_rom_ce    (rom_ce),
        .o_rom_addr  (rom_addr),
        .i_rom_inst  (rom_inst)
    );

    assign rom_inst = mem[rom_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 64; k++) mem[k] = 32'h5A00_0000 + k * 32'h0001_0101;

        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h8;
        if_flush = 1'b0;
        dp_req   = 1'b0;
        dp_addr  = 32'h0;
        repeat (2) cyc();
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_dp_rvalid", dp_rvalid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dp_rdata", dp_rdata, 0);
        check("rst_dp_err", dp_err, 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_if_gnt", if_gnt, 1);
        cyc();
        check("post_rst_if_rvalid", if_rvalid, 1);
        check("post_rst_if_rdata", if_rdata, mem[2]);

        // IF streaming, one request per cycle
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(i * 4);
            #1;
            check("stream_if_gnt", if_gnt, 1);
            check("stream_rom_addr", rom_addr, 32'(i * 4));
            cyc();
            check("stream_if_rvalid", if_rvalid, 1);
            check("stream_if_rdata", if_rdata, mem[i]);
        end

        // Starvation: DP denied four cycles, forced on the fifth
        if_addr = 32'h30;
        dp_req  = 1'b1;
        dp_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("starve_if_gnt", if_gnt, 1);
            check("starve_dp_gnt", dp_gnt, 0);
            cyc();
        end
        check("force_dp_gnt", dp_gnt, 1);
        check("force_if_gnt", if_gnt, 0);
        check("force_rom_addr", rom_addr, 32'h10);
        cyc();
        check("force_dp_rvalid", dp_rvalid, 1);
        check("force_dp_rdata", dp_rdata, mem[4]);
        check("force_if_rvalid", if_rvalid, 0);
        check("force_dp_err", dp_err, 0);
        dp_addr = 32'h14;
        #1;
        check("cnt_cleared_if_gnt", if_gnt, 1);
        check("cnt_cleared_dp_gnt", dp_gnt, 0);
        cyc();
        dp_req = 1'b0;

        // Flush kills the same-cycle IF grant
        if_addr  = 32'h20;
        if_flush = 1'b1;
        #1;
        check("flush_if_gnt", if_gnt, 1);
        cyc();
        if_flush = 1'b0;
        if_addr  = 32'h24;
        check("flush_if_rvalid", if_rvalid, 0);
        cyc();
        if_req   = 1'b0;
        if_flush = 1'b1;
        #1;
        check("late_flush_if_rvalid", if_rvalid, 1);
        check("late_flush_if_rdata", if_rdata, mem[9]);
        cyc();
        if_flush = 1'b0;

        // DP alone: aligned, then misaligned
        dp_req  = 1'b1;
        dp_addr = 32'h18;
        #1;
        check("dp_alone_gnt", dp_gnt, 1);
        cyc();
        check("dp_al_rvalid", dp_rvalid, 1);
        check("dp_al_rdata", dp_rdata, mem[6]);
        check("dp_al_err", dp_err, 0);
        dp_addr = 32'h13;
        #1;
        check("dp_mis_gnt", dp_gnt, 1);
        cyc();
        dp_req = 1'b0;
        check("dp_mis_rvalid", dp_rvalid, 1);
        check("dp_mis_err", dp_err, 1);
        check("dp_mis_rdata", dp_rdata, mem[4]);

        // Idle
        #1;
        check("idle_rom_ce", rom_ce, 0);
        check("idle_rom_addr", rom_addr, 0);
        cyc();
        check("idle_if_rvalid", if_rvalid, 0);
        check("idle_dp_rvalid", dp_rvalid, 0);
        check("idle_dp_err", dp_err, 0);

        // Reset mid-flight drops the pending response
        dp_req  = 1'b1;
        dp_addr = 32'h8;
        cyc();
        dp_req = 1'b0;
        check("pre_rst_dp_rvalid", dp_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dp_rvalid", dp_rvalid, 0);
        check("mid_rst_dp_rdata", dp_rdata, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
